// File: rtl/tlb_if.sv
// TLB port bundle.
//   Search port 0 (fetch) and search port 1 (data / TLBP):
//     sN_vpn2, sN_odd_page, sN_asid in; sN_found, sN_index, sN_pfn, sN_c,
//     sN_d, sN_v out.
//   Write port (TLBWI): we, w_index and the w_* entry fields in.
//   Read port (TLBR): r_index in; the r_* fields of that entry out.
// The slave modport is the TLB side and the master modport is the requester side.
// None of the ports carries a handshake. Search and read are combinational and
// always valid. A write with we=1 is accepted at every rising edge, so no ready
// signal exists.
interface tlb_if #(
  parameter int TLBNUM = 16
);
  localparam int IDXW = $clog2(TLBNUM);

  logic [18:0]     s0_vpn2;
  logic            s0_odd_page;
  logic [7:0]      s0_asid;
  logic            s0_found;
  logic [IDXW-1:0] s0_index;
  logic [19:0]     s0_pfn;
  logic [2:0]      s0_c;
  logic            s0_d;
  logic            s0_v;

  logic [18:0]     s1_vpn2;
  logic            s1_odd_page;
  logic [7:0]      s1_asid;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [19:0]     s1_pfn;
  logic [2:0]      s1_c;
  logic            s1_d;
  logic            s1_v;

  logic            we;
  logic [IDXW-1:0] w_index;
  logic [18:0]     w_vpn2;
  logic [7:0]      w_asid;
  logic            w_g;
  logic [19:0]     w_pfn0;
  logic [2:0]      w_c0;
  logic            w_d0;
  logic            w_v0;
  logic [19:0]     w_pfn1;
  logic [2:0]      w_c1;
  logic            w_d1;
  logic            w_v1;

  logic [IDXW-1:0] r_index;
  logic [18:0]     r_vpn2;
  logic [7:0]      r_asid;
  logic            r_g;
  logic [19:0]     r_pfn0;
  logic [2:0]      r_c0;
  logic            r_d0;
  logic            r_v0;
  logic [19:0]     r_pfn1;
  logic [2:0]      r_c1;
  logic            r_d1;
  logic            r_v1;

  modport slave (
    input  s0_vpn2, s0_odd_page, s0_asid,
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input  s1_vpn2, s1_odd_page, s1_asid,
    output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input  we, w_index, w_vpn2, w_asid, w_g,
    input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    input  r_index,
    output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
    output r_pfn1, r_c1, r_d1, r_v1
  );

  modport master (
    output s0_vpn2, s0_odd_page, s0_asid,
    input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_vpn2, s1_odd_page, s1_asid,
    input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output we, w_index, w_vpn2, w_asid, w_g,
    output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    output r_index,
    input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
    input  r_pfn1, r_c1, r_d1, r_v1
  );
endinterface

// File: rtl/tlb.sv
// Fully associative MIPS-style TLB with two search ports and one read/write port.
// Ports:
//   clk    : clock. All storage updates happen on its rising edge.
//   resetn : asynchronous, active-low clear of every entry.
//   bus    : tlb_if.slave with the two search ports, the write port (TLBWI)
//            and the read port (TLBR).
// Each entry maps a VPN2 page pair to an even and an odd physical page.
// Searches and reads are combinational against the registered storage. A write
// therefore becomes visible only in the cycle after its edge.
module tlb #(
  parameter int TLBNUM = 16
) (
  input  logic  clk,
  input  logic  resetn,
  tlb_if.slave  bus
);
  localparam int IDXW = $clog2(TLBNUM);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  entry_t tlb_q [TLBNUM];
  entry_t tlb_d [TLBNUM];
  entry_t w_e;

  // Returns the lowest set bit position. The loop scans downwards so the lowest hit is assigned last and wins.
  function automatic logic [IDXW-1:0] lowest(input logic [TLBNUM-1:0] m);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  // ---------------- storage ----------------
  always_comb begin
    w_e = '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
            pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
            pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1};
    tlb_d = tlb_q;
    // Indices at or beyond TLBNUM do not exist. A write to one of them is dropped and never aliases onto another entry.
    if (bus.we && (32'(bus.w_index) < TLBNUM)) tlb_d[bus.w_index] = w_e;
  end

  // The asynchronous clear takes priority over a concurrent write, so no partial entry can survive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) tlb_q[i] <= '0;
    end else begin
      tlb_q <= tlb_d;
    end
  end

  // ---------------- search ports ----------------
  // The valid bits deliberately play no part in matching.
  logic [TLBNUM-1:0] s0_match, s1_match;
  logic [IDXW-1:0]   s0_idx, s1_idx;
  entry_t            s0_e, s1_e;

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      s0_match[i] = (tlb_q[i].vpn2 == bus.s0_vpn2) &&
                    (tlb_q[i].g || (tlb_q[i].asid == bus.s0_asid));
      s1_match[i] = (tlb_q[i].vpn2 == bus.s1_vpn2) &&
                    (tlb_q[i].g || (tlb_q[i].asid == bus.s1_asid));
    end
  end

  assign s0_idx = lowest(s0_match);
  assign s1_idx = lowest(s1_match);
  assign s0_e   = tlb_q[s0_idx];
  assign s1_e   = tlb_q[s1_idx];

  // On a miss every output is held at zero rather than showing entry 0.
  always_comb begin
    bus.s0_found = 1'b0;
    bus.s0_index = '0;
    bus.s0_pfn   = '0;
    bus.s0_c     = '0;
    bus.s0_d     = 1'b0;
    bus.s0_v     = 1'b0;
    if (|s0_match) begin
      bus.s0_found = 1'b1;
      bus.s0_index = s0_idx;
      if (bus.s0_odd_page)
        {bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v} = {s0_e.pfn1, s0_e.c1, s0_e.d1, s0_e.v1};
      else
        {bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v} = {s0_e.pfn0, s0_e.c0, s0_e.d0, s0_e.v0};
    end
  end

  always_comb begin
    bus.s1_found = 1'b0;
    bus.s1_index = '0;
    bus.s1_pfn   = '0;
    bus.s1_c     = '0;
    bus.s1_d     = 1'b0;
    bus.s1_v     = 1'b0;
    if (|s1_match) begin
      bus.s1_found = 1'b1;
      bus.s1_index = s1_idx;
      if (bus.s1_odd_page)
        {bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v} = {s1_e.pfn1, s1_e.c1, s1_e.d1, s1_e.v1};
      else
        {bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v} = {s1_e.pfn0, s1_e.c0, s1_e.d0, s1_e.v0};
    end
  end

  // ---------------- read port ----------------
  entry_t r_e;

  always_comb begin
    r_e = '0;
    if (32'(bus.r_index) < TLBNUM) r_e = tlb_q[bus.r_index];
  end

  assign bus.r_vpn2 = r_e.vpn2;
  assign bus.r_asid = r_e.asid;
  assign bus.r_g    = r_e.g;
  assign bus.r_pfn0 = r_e.pfn0;
  assign bus.r_c0   = r_e.c0;
  assign bus.r_d0   = r_e.d0;
  assign bus.r_v0   = r_e.v0;
  assign bus.r_pfn1 = r_e.pfn1;
  assign bus.r_c1   = r_e.c1;
  assign bus.r_d1   = r_e.d1;
  assign bus.r_v1   = r_e.v1;
endmodule
